// File: rtl/uart_pkg.sv
// uart_pkg: FSM encoding, byte width and clog2 shared by the UART frame arbiter.
package uart_pkg;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE, DONE} state_t;

    // Never returns less than 1 so one-entry counters still get a real bit.
    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) ;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/uart_tx_frame_arbiter_if.sv
// uart_tx_frame_arbiter_if: requester handshake plus byte-transmitter handshake.
interface uart_tx_frame_arbiter_if
    import uart_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int WORD_BYTES = 4
);
    logic [N_REQ-1:0]                  req_valid;
    logic [N_REQ*WORD_BYTES*BYTE_W-1:0] req_data;
    logic [N_REQ-1:0]                  req_done;
    logic [N_REQ-1:0]                  grant;
    logic                              busy;
    logic                              tx_ld;
    logic                              tx_en;
    logic [BYTE_W-1:0]                 tx_byte;
    logic                              tx_empty;

    modport master (
        output req_valid, req_data, tx_empty,
        input  req_done, grant, busy, tx_ld, tx_en, tx_byte
    );
    modport slave (
        input  req_valid, req_data, tx_empty,
        output req_done, grant, busy, tx_ld, tx_en, tx_byte
    );
endinterface

// File: rtl/uart_tx_frame_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at/after ptr.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int  N_REQ = 4,
    localparam int PW    = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PW-1:0]    idx
);
    int j;

    // Scan farthest offset first so the nearest valid request overwrites it.
    always_comb begin
        grant = '0;
        idx   = '0;
        j     = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N_REQ;
            if (req[j]) begin
                grant = N_REQ'(1) << j;
                idx   = PW'(j);
            end
        end
    end
endmodule

// File: rtl/uart_tx_frame_arbiter.sv
// uart_tx_frame_arbiter: round-robin sharing of one byte UART transmitter, words sent MSB byte first.
module uart_tx_frame_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int WORD_BYTES = 4
) (
    input logic                     clk,
    input logic                     reset,
    uart_tx_frame_arbiter_if.slave  bus
);
    localparam int W  = BYTE_W * WORD_BYTES;
    localparam int CW = clog2(WORD_BYTES);
    localparam int PW = clog2(N_REQ);

    state_t           state, nxt;
    logic [W-1:0]     shift;
    logic [CW-1:0]    cnt;
    logic [PW-1:0]    ptr, sel, arb_idx;
    logic [N_REQ-1:0] grant, arb_grant;
    logic             busy, last;

    assign last = cnt == CW'(WORD_BYTES - 1);

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
            shift <= '0;
            cnt   <= '0;
            ptr   <= '0;
            sel   <= '0;
        end else begin
            state <= nxt;
            case (state)
                IDLE: if (|bus.req_valid) begin
                    grant <= arb_grant;
                    busy  <= 1'b1;
                    shift <= bus.req_data[arb_idx*W +: W];
                    cnt   <= '0;
                    sel   <= arb_idx;
                end
                WAIT_DONE: if (bus.tx_empty && !last) begin
                    shift <= shift << BYTE_W;
                    cnt   <= cnt + 1'b1;
                end
                DONE: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    ptr   <= (sel == PW'(N_REQ - 1)) ? '0 : sel + 1'b1;
                end
                LOAD, WAIT_BUSY: ;
                default: begin
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        nxt          = IDLE;
        bus.tx_ld    = state == LOAD;
        bus.tx_en    = state == WAIT_BUSY || state == WAIT_DONE;
        bus.req_done = (state == DONE) ? grant : '0;
        case (state)
            IDLE:      nxt = |bus.req_valid ? LOAD : IDLE;
            LOAD:      nxt = bus.tx_empty ? WAIT_BUSY : LOAD;
            WAIT_BUSY: nxt = bus.tx_empty ? WAIT_BUSY : WAIT_DONE;
            WAIT_DONE: nxt = bus.tx_empty ? (last ? DONE : LOAD) : WAIT_DONE;
            default:   nxt = IDLE;
        endcase
    end

    assign bus.grant   = grant;
    assign bus.busy    = busy;
    assign bus.tx_byte = shift[W-1 -: BYTE_W];
endmodule

// File: tb/tb_uart_tx_frame_arbiter.sv
// tb_uart_tx_frame_arbiter: directed checks of arbitration order, byte order, stalls and resets.
module tb_uart_tx_frame_arbiter;
    logic clk, rst, stall;
    int   total = 0, bad = 0;
    logic [7:0] byte_q[$];
    int   gq[$], dq[$];
    int   armed = 0, bsy = 0;

    uart_tx_frame_arbiter_if #(.N_REQ(4), .WORD_BYTES(4)) bus ();

    uart_tx_frame_arbiter #(.N_REQ(4), .WORD_BYTES(4)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Byte transmitter model: accepts a load, goes busy a few cycles, then reports empty again.
    initial begin
        bus.tx_empty = 1;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                armed = 0;
                bsy = 0;
                bus.tx_empty = 1;
            end else begin
                if (stall) bus.tx_empty = 0;
                else if (armed != 0) begin
                    armed = 0;
                    bus.tx_empty = 0;
                    bsy = 3;
                end else if (bsy > 0) begin
                    bsy--;
                    bus.tx_empty = (bsy == 0);
                end else bus.tx_empty = 1;
                if (bus.tx_empty && bus.tx_ld) begin
                    byte_q.push_back(bus.tx_byte);
                    armed = 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int oh2i(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic run(input int want, input bit clr);
        int got = 0, cyc = 0;
        logic [3:0] pg = bus.grant;
        while (got < want && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (bus.grant != 0 && bus.grant != pg) gq.push_back(oh2i(bus.grant));
            pg = bus.grant;
            if (bus.req_done != 0) begin
                dq.push_back(oh2i(bus.req_done));
                got++;
                if (clr) bus.req_valid = bus.req_valid & ~bus.req_done;
            end
        end
        if (got < want) chk("run_timeout", got, want);
    endtask

    task automatic wait_bytes(input int n);
        int cyc = 0;
        while (byte_q.size() < n && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk("wait_bytes", byte_q.size() >= n, 1);
    endtask

    task automatic do_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    task automatic chk_word(input string tag, input int b, input logic [31:0] w);
        chk(tag, byte_q.size() - b, 4);
        for (int i = 0; i < 4 && b + i < byte_q.size(); i++)
            chk(tag, byte_q[b+i], w[31-8*i -: 8]);
    endtask

    initial begin
        int b, nd;
        int exp_o[5] = '{0, 1, 2, 3, 0};
        rst = 1;
        stall = 0;
        bus.req_valid = '0;
        bus.req_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_grant", bus.grant, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ld", bus.tx_ld, 0);
        chk("rst_en", bus.tx_en, 0);
        chk("rst_byte", bus.tx_byte, 0);
        chk("rst_done", bus.req_done, 0);
        rst = 0;
        @(negedge clk);

        // single requester
        b = byte_q.size();
        bus.req_data[31:0] = 32'hDEADBEEF;
        bus.req_valid = 4'b0001;
        run(1, 1);
        chk_word("single_bytes", b, 32'hDEADBEEF);
        chk("single_done_idx", dq[0], 0);
        repeat (20) @(negedge clk);
        chk("single_done_once", bus.req_done, 0);
        chk("single_idle_grant", bus.grant, 0);

        // contention, all four held
        do_reset();
        gq.delete();
        dq.delete();
        b = byte_q.size();
        bus.req_data = 128'hD0D1D2D3_C0C1C2C3_B0B1B2B3_A0A1A2A3;
        bus.req_valid = 4'b1111;
        run(5, 0);
        bus.req_valid = 4'b0000;
        chk("cont_ngrant", gq.size(), 5);
        chk("cont_nbytes", byte_q.size() - b, 20);
        for (int w = 0; w < 5 && w < gq.size(); w++) begin
            chk("cont_grant", gq[w], exp_o[w]);
            chk("cont_done", dq[w], exp_o[w]);
        end
        for (int k = 0; k < 20 && b + k < byte_q.size(); k++)
            chk("cont_byte", byte_q[b+k], 8'hA0 + 8'h10 * exp_o[k/4] + k % 4);

        // pointer: serve 2, then 0 and 2 together
        @(negedge clk);
        gq.delete();
        bus.req_valid = 4'b0100;
        run(1, 1);
        gq.delete();
        bus.req_valid = 4'b0101;
        run(2, 1);
        chk("ptr_first", gq[0], 0);
        chk("ptr_second", gq.size() > 1 ? gq[1] : -1, 2);

        // slow transmitter held full while loading
        stall = 1;
        repeat (2) @(negedge clk);
        dq.delete();
        b = byte_q.size();
        bus.req_data[63:32] = 32'hCAFEF00D;
        bus.req_valid = 4'b0010;
        nd = 0;
        while (!bus.tx_ld && nd < 20) begin
            @(negedge clk);
            nd++;
        end
        chk("slow_ld_seen", bus.tx_ld, 1);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            chk("slow_ld", bus.tx_ld, 1);
            chk("slow_byte", bus.tx_byte, 8'hCA);
            chk("slow_en", bus.tx_en, 0);
        end
        stall = 0;
        run(1, 1);
        chk_word("slow_bytes", b, 32'hCAFEF00D);
        chk("slow_done_idx", dq[0], 1);

        // reset in the middle of a word
        @(negedge clk);
        b = byte_q.size();
        bus.req_data[31:0] = 32'h11223344;
        bus.req_valid = 4'b0001;
        nd = 0;
        for (int c = 0; c < 500 && byte_q.size() < b + 2; c++) begin
            @(negedge clk);
            if (bus.req_done != 0) nd++;
        end
        chk("mid_two_bytes", byte_q.size() - b, 2);
        chk("mid_b0", byte_q[b], 8'h11);
        rst = 1;
        #1;
        chk("mid_grant", bus.grant, 0);
        chk("mid_ld", bus.tx_ld, 0);
        chk("mid_en", bus.tx_en, 0);
        chk("mid_busy", bus.busy, 0);
        chk("mid_done", bus.req_done, 0);
        chk("mid_no_done", nd, 0);
        repeat (2) @(negedge clk);
        rst = 0;
        dq.delete();
        b = byte_q.size();
        run(1, 1);
        chk_word("mid_restart", b, 32'h11223344);

        // requester drops valid and changes data after first byte
        @(negedge clk);
        dq.delete();
        b = byte_q.size();
        bus.req_data[63:32] = 32'h55667788;
        bus.req_valid = 4'b0010;
        wait_bytes(b + 1);
        bus.req_valid = 4'b0000;
        bus.req_data[63:32] = 32'hFFFFFFFF;
        run(1, 1);
        chk_word("drop_bytes", b, 32'h55667788);
        chk("drop_done_idx", dq[0], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
